// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 16-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_arbiter16_demux16.sv
// One-hot decoder: drives out_o[sel_i] with in_i, every other bit zero.
module demux16
  import arb_pkg::*;
(
  input  logic             in_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic [N_REQ-1:0] out_o
);

  // Route the enable onto the selected line only.
  always_comb begin
    out_o        = '0;
    out_o[sel_i] = in_i;
  end

endmodule : demux16

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with registered, held grants.
// Optional forced revoke after HOLD_MAX grant cycles: define ARB_TIMEOUT_EN.
module rr_arbiter16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arbiter16: HOLD_MAX must be in 1..255");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic             timeout_q, timeout_d;

  // First set request scanning p, p+1, ... with mod-16 wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + IDX_W'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;
  logic       expired;

  // Hold counter: zero while idle so it starts at 0 on the first grant cycle.
  always_comb begin
    hold_d  = (state_q == ARB_GRANT) ? hold_q + 8'd1 : 8'd0;
    expired = (state_q == ARB_GRANT) && (hold_q == HOLD_LAST);
  end
`else
  logic expired;
  assign expired = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, hold in GRANT until release or expiry.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_GRANT;
          owner_d = rr_pick(req, ptr_q);
        end
      end
      ARB_GRANT: begin
        if (!req[owner_q]) begin
          // A normal release wins over a simultaneous expiry: no pulse.
          state_d = ARB_IDLE;
          ptr_d   = owner_q + IDX_W'(1);
        end else if (expired) begin
          state_d   = ARB_IDLE;
          ptr_d     = owner_q + IDX_W'(1);
          timeout_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous reset that overrides every other event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) hold_q <= 8'd0;
    else       hold_q <= hold_d;
  end
`endif

  assign busy    = (state_q == ARB_GRANT);
  assign owner   = owner_q;
  assign timeout = timeout_q;

  demux16 u_demux16 (
    .in_i  (busy),
    .sel_i (owner_q),
    .out_o (gnt)
  );

  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt));

endmodule : rr_arbiter16
